// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared types and helpers for the fetch-side instruction queue
// Falls back to 32-bit widths only when the shared fetch definitions have not been seen.
`ifndef IWIDTH
`define IWIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package instr_queue_pkg;

   localparam int unsigned IQ_IWIDTH   = `IWIDTH;
   localparam int unsigned IQ_PC_WIDTH = `PC_WIDTH;

   typedef struct packed {
      logic [IQ_IWIDTH-1:0]   instr;
      logic [IQ_PC_WIDTH-1:0] pc;
   } iq_entry_t;

   // Free slots must exceed the fetches that may still land, so nothing in flight can overflow.
   function automatic logic iq_has_credit(input int unsigned depth,
                                          input int unsigned count,
                                          input int unsigned inflight);
      return (depth - count) > inflight;
   endfunction

endpackage

// File: rtl/iq_fifo_mem.sv
// rtl/iq_fifo_mem.sv - DEPTH-entry register array, one write port, asynchronous read
module iq_fifo_mem
   import instr_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  iq_entry_t       wr_data,
   input  logic [AW-1:0]   rd_addr,
   output iq_entry_t       rd_data
);

   iq_entry_t mem_q [DEPTH];
   iq_entry_t mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Contents are not reset; the queue masks every slot that is not occupied.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-side instruction FIFO with credit back-pressure and redirect flush
module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned INFLIGHT = 2
) (
   input  logic                               iq_clk,
   input  logic                               iq_rst,
   input  logic                               iq_i_ce,
   input  logic [IQ_IWIDTH-1:0]               iq_i_instr,
   input  logic [IQ_PC_WIDTH-1:0]             iq_i_pc,
   input  logic                               iq_i_flush,
   input  logic                               iq_i_stall,
   output logic                               iq_o_fetch_ce,
   output logic                               iq_o_ce,
   output logic [IQ_IWIDTH-1:0]               iq_o_instr,
   output logic [IQ_PC_WIDTH-1:0]             iq_o_pc,
   output logic [$clog2(DEPTH+1)-1:0]         iq_o_count,
   output logic                               iq_o_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned DW = (INFLIGHT > 0) ? $clog2(INFLIGHT + 1) : 1;

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [DW-1:0] INFLIGHT_C = DW'(INFLIGHT);

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [DW-1:0] drop_q, drop_d;
   logic          overflow_q, overflow_d;
   logic          fetch_ce_q, fetch_ce_d;

   logic          head_valid;
   logic          pop;
   logic          free;
   logic          drop_active;
   logic          accept;
   logic          push;

   iq_entry_t     wr_entry;
   iq_entry_t     rd_entry;

   always_comb begin
      head_valid  = (count_q != '0);
      pop         = head_valid & ~iq_i_stall;
      free        = (count_q != DEPTH_C) | pop;
      drop_active = (drop_q != '0);
      accept      = iq_rst & iq_i_ce & ~iq_i_flush & ~drop_active;
      push        = accept & free;

      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      drop_d      = drop_active ? (drop_q - DW'(1)) : drop_q;
      overflow_d  = overflow_q | (accept & ~free);

      if (iq_i_flush) begin
         // Redirect: everything queued or still in the fetch pipe is wrong-path.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         drop_d   = INFLIGHT_C;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      fetch_ce_d = ~iq_i_flush & iq_has_credit(DEPTH, 32'(count_d), INFLIGHT);
   end

   always_ff @(posedge iq_clk) begin
      if (!iq_rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         drop_q     <= '0;
         overflow_q <= 1'b0;
         fetch_ce_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         drop_q     <= drop_d;
         overflow_q <= overflow_d;
         fetch_ce_q <= fetch_ce_d;
      end
   end

   assign wr_entry.instr = iq_i_instr;
   assign wr_entry.pc    = iq_i_pc;

   iq_fifo_mem #(
      .DEPTH   (DEPTH),
      .AW      (AW)
   ) u_mem (
      .clk     (iq_clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_entry)
   );

   assign iq_o_ce       = head_valid;
   assign iq_o_instr    = head_valid ? rd_entry.instr : '0;
   assign iq_o_pc       = head_valid ? rd_entry.pc    : '0;
   assign iq_o_count    = count_q;
   assign iq_o_overflow = overflow_q;
   assign iq_o_fetch_ce = fetch_ce_q;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed bench for instr_queue with a queue-based reference model
module tb_instr_queue;
   import instr_queue_pkg::*;

   localparam int DEPTH    = 4;
   localparam int INFLIGHT = 2;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        ce;
   logic [IQ_IWIDTH-1:0]        i_instr;
   logic [IQ_PC_WIDTH-1:0]      i_pc;
   logic                        flush;
   logic                        stall;
   logic                        o_fetch_ce;
   logic                        o_ce;
   logic [IQ_IWIDTH-1:0]        o_instr;
   logic [IQ_PC_WIDTH-1:0]      o_pc;
   logic [$clog2(DEPTH+1)-1:0]  o_count;
   logic                        o_overflow;

   always #5 clk = ~clk;

   instr_queue #(
      .DEPTH         (DEPTH),
      .INFLIGHT      (INFLIGHT)
   ) dut (
      .iq_clk        (clk),
      .iq_rst        (rst),
      .iq_i_ce       (ce),
      .iq_i_instr    (i_instr),
      .iq_i_pc       (i_pc),
      .iq_i_flush    (flush),
      .iq_i_stall    (stall),
      .iq_o_fetch_ce (o_fetch_ce),
      .iq_o_ce       (o_ce),
      .iq_o_instr    (o_instr),
      .iq_o_pc       (o_pc),
      .iq_o_count    (o_count),
      .iq_o_overflow (o_overflow)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [IQ_IWIDTH-1:0] mk_instr(input logic [IQ_PC_WIDTH-1:0] pc);
      return IQ_IWIDTH'(pc) ^ IQ_IWIDTH'(32'hC0DE_0013);
   endfunction

   // Reference model: an ordered list of entries plus the drop window and sticky flag.
   iq_entry_t m_q[$];
   int        m_drop = 0;
   bit        m_ovf  = 1'b0;
   bit        m_fce  = 1'b0;
   bit        m_live = 1'b0;

   always @(posedge clk) begin
      bit popped;
      bit dropping;
      iq_entry_t e;
      if (!rst) begin
         m_q.delete();
         m_drop = 0;
         m_ovf  = 1'b0;
         m_fce  = 1'b0;
      end else if (flush) begin
         m_q.delete();
         m_drop = INFLIGHT;
         m_fce  = 1'b0;
      end else begin
         popped   = (m_q.size() > 0) && !stall;
         dropping = (m_drop > 0);
         if (dropping) m_drop--;
         if (popped) void'(m_q.pop_front());
         if (ce && !dropping) begin
            if (m_q.size() < DEPTH) begin
               e.instr = i_instr;
               e.pc    = i_pc;
               m_q.push_back(e);
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_fce = (DEPTH - m_q.size()) > INFLIGHT;
      end
      m_live = 1'b1;
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("cyc_ce",       longint'(o_ce),       longint'(m_q.size() != 0));
         check("cyc_count",    longint'(o_count),    longint'(m_q.size()));
         check("cyc_pc",       longint'(o_pc),       (m_q.size() != 0) ? longint'(m_q[0].pc) : 0);
         check("cyc_instr",    longint'(o_instr),    (m_q.size() != 0) ? longint'(m_q[0].instr) : 0);
         check("cyc_fetch_ce", longint'(o_fetch_ce), longint'(m_fce));
         check("cyc_overflow", longint'(o_overflow), longint'(m_ovf));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit c, input logic [IQ_PC_WIDTH-1:0] pc);
      ce      = c;
      i_pc    = pc;
      i_instr = mk_instr(pc);
      step();
   endtask

   initial begin
      logic [IQ_PC_WIDTH-1:0] stream_pcs [4];
      stream_pcs[0] = 'h0;
      stream_pcs[1] = 'h4;
      stream_pcs[2] = 'h8;
      stream_pcs[3] = 'hC;

      rst = 1'b0; ce = 1'b1; flush = 1'b0; stall = 1'b0;
      i_pc = 'h3C; i_instr = mk_instr('h3C);

      // Reset with fetch strobes present
      repeat (3) step();
      check("rst_ce",       longint'(o_ce),       0);
      check("rst_count",    longint'(o_count),    0);
      check("rst_fetch_ce", longint'(o_fetch_ce), 0);
      check("rst_overflow", longint'(o_overflow), 0);
      rst = 1'b1; ce = 1'b0;
      step();
      check("release_fetch_ce", longint'(o_fetch_ce), 1);

      // Streaming, no stall
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, stream_pcs[i]);
         check("stream_pc",    longint'(o_pc),    longint'(stream_pcs[i]));
         check("stream_count", longint'(o_count), 1);
      end
      beat(1'b0, 'h0);
      check("stream_drained", longint'(o_count), 0);

      // Stall and fill
      stall = 1'b1;
      beat(1'b1, 'h100);
      check("fill_fce_c1", longint'(o_fetch_ce), 1);
      beat(1'b1, 'h104);
      check("fill_count2", longint'(o_count),    2);
      check("fill_fce_c2", longint'(o_fetch_ce), 0);
      beat(1'b1, 'h108);
      beat(1'b1, 'h10C);
      check("fill_count4", longint'(o_count),    4);
      check("fill_ovf",    longint'(o_overflow), 0);
      check("fill_head",   longint'(o_pc),       'h100);

      // Full with simultaneous pop and push
      stall = 1'b0;
      beat(1'b1, 'h110);
      check("full_pp_count", longint'(o_count),    4);
      check("full_pp_head",  longint'(o_pc),       'h104);
      check("full_pp_ovf",   longint'(o_overflow), 0);

      // Drain until credit returns
      beat(1'b0, 'h0);
      check("drain_fce_c3", longint'(o_fetch_ce), 0);
      beat(1'b0, 'h0);
      beat(1'b0, 'h0);
      check("drain_count1", longint'(o_count),    1);
      check("drain_fce_c1", longint'(o_fetch_ce), 1);
      check("drain_head",   longint'(o_pc),       'h110);

      // Flush at count 3, then wrong-path beats in flight
      stall = 1'b1;
      beat(1'b1, 'h120);
      beat(1'b1, 'h124);
      check("pre_flush_count", longint'(o_count), 3);
      flush = 1'b1; ce = 1'b0;
      step();
      flush = 1'b0;
      check("flush_count", longint'(o_count),    0);
      check("flush_ce",    longint'(o_ce),       0);
      check("flush_fce",   longint'(o_fetch_ce), 0);
      beat(1'b1, 'h20);
      check("drop_20", longint'(o_count), 0);
      beat(1'b1, 'h24);
      check("drop_24", longint'(o_count), 0);
      beat(1'b1, 'h40);
      check("post_flush_count", longint'(o_count), 1);
      check("post_flush_head",  longint'(o_pc),    'h40);
      check("post_flush_instr", longint'(o_instr), longint'(mk_instr('h40)));

      // Forced overflow from an empty queue
      rst = 1'b0; ce = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         beat(1'b1, IQ_PC_WIDTH'('h200 + 4 * i));
         if (i == 3) check("ovf_before", longint'(o_overflow), 0);
      end
      check("ovf_set",   longint'(o_overflow), 1);
      check("ovf_count", longint'(o_count),    4);
      check("ovf_head",  longint'(o_pc),       'h200);
      stall = 1'b0;
      repeat (5) beat(1'b0, 'h0);
      check("ovf_sticky", longint'(o_overflow), 1);
      check("ovf_empty",  longint'(o_count),    0);
      rst = 1'b0;
      step();
      check("ovf_cleared", longint'(o_overflow), 0);
      rst = 1'b1;
      step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
